// File: rtl/alu_divider.sv
// Iterative restoring radix-2 divider for div/divu: one quotient bit per clock,
// quotient to LO (q), remainder to HI (r), with sign fix-up and divide-by-zero handling.
module alu_divider #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    // state  | meaning
    // S_IDLE | waiting for start; operands are sampled on the accepting edge
    // S_RUN  | one shift/trial-subtract per edge, 32 edges
    // S_FIX  | sign correction, result registered, done pulsed
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]    rem, quo, dvs;
    logic [CNT_BITS-1:0] cnt;
    logic                neg_q, neg_r, zero_pend;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH:0]      trial;
    logic [WIDTH-1:0]    q_fix, r_fix;

    assign a_mag = (sign_op && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sign_op && b[WIDTH-1]) ? -b : b;

    // 33-bit trial subtract; bit WIDTH set means the shifted remainder was smaller than the divisor
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (b == '0) ? S_FIX : S_RUN;
            S_RUN:   if (cnt == CNT_BITS'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q         <= '0;
            r         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        rem       <= '0;
                        cnt       <= '0;
                        dvs       <= b_mag;
                        neg_q     <= sign_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r     <= sign_op & a[WIDTH-1];
                        zero_pend <= (b == '0);
                        // on divide-by-zero the raw dividend rides in quo and becomes r
                        quo       <= (b == '0) ? a : a_mag;
                    end
                end
                S_RUN: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= zero_pend;
                    if (zero_pend) begin
                        q <= '1;
                        r <= quo;
                    end else begin
                        q <= q_fix;
                        r <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
